// File: rtl/audio_out_tdm.sv
// Serial audio DAC driver: I2S / left-justified stereo or TDM (up to 8 slots),
// with a 1-deep frame buffer behind a valid/ready handshake and underrun reporting.
module audio_out_tdm #(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 16,
  parameter int CHANNELS  = 2,
  parameter int BIT_TICKS = 16,
  parameter int MODE_I2S  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dac_clk,
  input  logic [CHANNELS*SAMPLE_W-1:0] snd_data,
  input  logic                         snd_valid,
  output logic                         snd_ready,
  output logic                         mclk,
  output logic                         bclk,
  output logic                         lrck,
  output logic                         sdin,
  output logic                         underrun
);

  localparam int FRAME_W  = CHANNELS * SAMPLE_W;
  localparam int FRAME_PW = CHANNELS * SLOT_W;
  localparam int TICK_W   = $clog2(BIT_TICKS);
  localparam int BIT_W    = $clog2(SLOT_W);
  localparam int SLOT_CW  = $clog2(CHANNELS);

  localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0]  TICK_HALF = TICK_W'(BIT_TICKS / 2);
  localparam logic [BIT_W-1:0]   BIT_MAX   = BIT_W'(SLOT_W - 1);
  localparam logic [SLOT_CW-1:0] SLOT_MAX  = SLOT_CW'(CHANNELS - 1);

  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [SLOT_CW-1:0]  slot_q, slot_d;
  logic [FRAME_W-1:0]  buf_q, buf_d;
  logic                full_q, full_d;
  logic [FRAME_PW-1:0] shift_q, shift_d;
  logic                mclk_q, mclk_d;
  logic                bclk_q, bclk_d;
  logic                lrck_q, lrck_d;
  logic                sdin_q, sdin_d;
  logic                underrun_q, underrun_d;

  logic [FRAME_PW-1:0] buf_padded;
  logic                xfer, bit_end, eof;

  // Buffer laid out as the serial stream: ch0 slot first, each sample MSB-aligned, zero pad below.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pad
    logic [SAMPLE_W+SLOT_W-1:0] ext;
    assign ext = {buf_q[gi*SAMPLE_W +: SAMPLE_W], SLOT_W'(0)};
    assign buf_padded[FRAME_PW-1-gi*SLOT_W -: SLOT_W] = ext[SAMPLE_W+SLOT_W-1 -: SLOT_W];
  end

  assign xfer    = snd_valid && !full_q;
  assign bit_end = dac_clk && (tick_q == TICK_MAX);
  assign eof     = bit_end && (bit_q == BIT_MAX) && (slot_q == SLOT_MAX);

  always_comb begin
    tick_d     = tick_q;
    bit_d      = bit_q;
    slot_d     = slot_q;
    buf_d      = buf_q;
    full_d     = full_q;
    shift_d    = shift_q;
    mclk_d     = mclk_q;
    bclk_d     = bclk_q;
    lrck_d     = lrck_q;
    sdin_d     = sdin_q;
    underrun_d = 1'b0;

    if (dac_clk) begin
      tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
      mclk_d = ~mclk_q;
      bclk_d = (tick_d >= TICK_HALF);
      if (bit_end) begin
        bit_d = (bit_q == BIT_MAX) ? '0 : bit_q + 1'b1;
        if (bit_q == BIT_MAX) begin
          slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + 1'b1;
        end
        shift_d = eof ? buf_padded : (shift_q << 1);
        // I2S outputs the bit that just finished, giving the one-bit delay across slot/frame edges.
        sdin_d = (MODE_I2S != 0) ? shift_q[FRAME_PW-1] : shift_d[FRAME_PW-1];
        if (CHANNELS == 2) begin
          lrck_d = slot_d[0];
        end else begin
          lrck_d = (slot_d == '0) && (bit_d == '0);
        end
      end
    end

    if (xfer) begin
      buf_d = snd_data;
    end
    if (eof) begin
      full_d     = xfer;
      underrun_d = !full_q;
    end else if (xfer) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= '0;
      bit_q      <= '0;
      slot_q     <= '0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      shift_q    <= '0;
      mclk_q     <= 1'b0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdin_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      slot_q     <= slot_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      shift_q    <= shift_d;
      mclk_q     <= mclk_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      sdin_q     <= sdin_d;
      underrun_q <= underrun_d;
    end
  end

  assign snd_ready = !full_q;
  assign mclk      = mclk_q;
  assign bclk      = bclk_q;
  assign lrck      = lrck_q;
  assign sdin      = sdin_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_audio_out_tdm.sv
// Directed bench for audio_out_tdm: stereo I2S, stereo left-justified and 4-slot TDM
// instances driven side by side with hand-computed serial patterns.
module tb_audio_out_tdm;

  logic clk = 1'b0;
  logic rst_n;
  logic dac_clk;

  logic [31:0] da;
  logic        va;
  logic [95:0] dt;
  logic        vt;

  logic ra, mclk_a, bclk_a, lrck_a, sdin_a, ur_a;
  logic rb, mclk_b, bclk_b, lrck_b, sdin_b, ur_b;
  logic rt, mclk_t, bclk_t, lrck_t, sdin_t, ur_t;

  int checks = 0;
  int errors = 0;

  int ur_hi_a = 0, ur_hi_b = 0, ur_hi_t = 0, ur_rise_a = 0;
  logic ur_a_prev = 1'b0;
  int ur_base_t;

  logic [127:0] sa, sb, st, la, lb, lt;

  always #5 clk = ~clk;

  audio_out_tdm #(.SAMPLE_W(16), .SLOT_W(16), .CHANNELS(2), .BIT_TICKS(4), .MODE_I2S(1)) u_i2s (
    .clk(clk), .rst_n(rst_n), .dac_clk(dac_clk), .snd_data(da), .snd_valid(va),
    .snd_ready(ra), .mclk(mclk_a), .bclk(bclk_a), .lrck(lrck_a), .sdin(sdin_a), .underrun(ur_a));

  audio_out_tdm #(.SAMPLE_W(16), .SLOT_W(16), .CHANNELS(2), .BIT_TICKS(4), .MODE_I2S(0)) u_lj (
    .clk(clk), .rst_n(rst_n), .dac_clk(dac_clk), .snd_data(da), .snd_valid(va),
    .snd_ready(rb), .mclk(mclk_b), .bclk(bclk_b), .lrck(lrck_b), .sdin(sdin_b), .underrun(ur_b));

  audio_out_tdm #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(4), .BIT_TICKS(4), .MODE_I2S(1)) u_tdm (
    .clk(clk), .rst_n(rst_n), .dac_clk(dac_clk), .snd_data(dt), .snd_valid(vt),
    .snd_ready(rt), .mclk(mclk_t), .bclk(bclk_t), .lrck(lrck_t), .sdin(sdin_t), .underrun(ur_t));

  always @(negedge clk) begin
    if (ur_a) ur_hi_a <= ur_hi_a + 1;
    if (ur_b) ur_hi_b <= ur_hi_b + 1;
    if (ur_t) ur_hi_t <= ur_hi_t + 1;
    if (ur_a && !ur_a_prev) ur_rise_a <= ur_rise_a + 1;
    ur_a_prev <= ur_a;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bit = 4 dac_clk ticks; sample mid-bit while bclk is high.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (2) @(posedge clk);
      #1;
      sa = {sa[126:0], sdin_a};
      sb = {sb[126:0], sdin_b};
      st = {st[126:0], sdin_t};
      la = {la[126:0], lrck_a};
      lb = {lb[126:0], lrck_b};
      lt = {lt[126:0], lrck_t};
      $display("bit %0d: sdin i2s=%b lj=%b tdm=%b lrck i2s=%b tdm=%b", i, sdin_a, sdin_b, sdin_t, lrck_a, lrck_t);
      repeat (2) @(posedge clk);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    dac_clk = 1'b1;
    va = 1'b0; da = '0;
    vt = 1'b0; dt = '0;
    sa = '0; sb = '0; st = '0; la = '0; lb = '0; lt = '0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({ra, rb, rt, sdin_a, bclk_a, lrck_a, mclk_a, ur_a, sdin_b, lrck_b, sdin_t, lrck_t, ur_t}),
        128'(13'b1110000000000));

    // Frame 1: accept L=8001 R=7FFE; output stays zero.
    rst_n = 1'b1;
    va = 1'b1; da = 32'h7FFE_8001;
    fork
      capture(32);
      begin
        @(negedge clk);
        va = 1'b0;
        chk("ready_drop_after_accept", 128'({ra, rb}), 128'(2'b00));
        @(negedge clk);
        chk("bclk_high_second_half", 128'({bclk_a, bclk_b, bclk_t}), 128'(3'b111));
      end
    join
    chk("f1_i2s_zero", 128'(sa[31:0]), 128'(32'h0));
    chk("f1_lj_zero", 128'(sb[31:0]), 128'(32'h0));
    chk("f1_lrck", 128'({la[31:0], lb[31:0]}), 128'({32'h0000_FFFF, 32'h0000_FFFF}));

    capture(32);
    chk("f2_i2s", 128'(sa[31:0]), 128'(32'h4000_BFFF));
    chk("f2_lj", 128'(sb[31:0]), 128'(32'h8001_7FFE));
    chk("f2_lrck", 128'(la[31:0]), 128'(32'h0000_FFFF));
    chk("f1_end_no_underrun", 128'(ur_hi_a), 128'(0));

    // Frames 3..5 repeat F with no new data.
    capture(32);
    chk("f3_i2s_repeat", 128'(sa[31:0]), 128'(32'h4000_BFFF));
    chk("f3_lj_repeat", 128'(sb[31:0]), 128'(32'h8001_7FFE));
    chk("f2_end_underrun", 128'({ur_hi_a, ur_hi_b}), 128'({32'd1, 32'd1}));
    capture(32);
    capture(32);
    chk("f5_i2s_repeat", 128'(sa[31:0]), 128'(32'h4000_BFFF));
    chk("f5_lj_repeat", 128'(sb[31:0]), 128'(32'h8001_7FFE));
    chk("underrun_pulses_3", 128'({ur_hi_a, ur_rise_a, ur_hi_b}), 128'({32'd3, 32'd3, 32'd3}));

    // Backpressure: A then B offered back to back during frame 6.
    fork
      begin
        @(negedge clk);
        va = 1'b1; da = 32'h1234_ABCD;
        @(negedge clk);
        chk("bp_ready_low_after_a", 128'({ra, rb}), 128'(2'b00));
        da = 32'h0F0F_F00F;
        for (int k = 0; k < 600 && ra !== 1'b1; k++) @(negedge clk);
        chk("bp_ready_returns", 128'({ra, rb}), 128'(2'b11));
        @(negedge clk);
        va = 1'b0;
        chk("bp_b_accepted", 128'({ra, rb}), 128'(2'b00));
      end
    join_none
    capture(32);
    chk("f6_i2s_still_f", 128'(sa[31:0]), 128'(32'h4000_BFFF));
    capture(32);
    chk("f7_i2s_a", 128'(sa[31:0]), 128'(32'h55E6_891A));
    chk("f7_lj_a", 128'(sb[31:0]), 128'(32'hABCD_1234));
    capture(32);
    chk("f8_i2s_b", 128'(sa[31:0]), 128'(32'h7807_8787));
    chk("f8_lj_b", 128'(sb[31:0]), 128'(32'hF00F_0F0F));
    chk("bp_no_extra_underrun", 128'(ur_hi_a), 128'(32'd4));

    // Reset asserted at slot 1 bit 7 with the buffer full.
    #1;
    va = 1'b1; da = 32'h5555_AAAA;
    repeat (94) @(posedge clk);
    #1;
    va = 1'b0;
    chk("pre_reset_state", 128'({ra, rb, lrck_a, bclk_a}), 128'(4'b0011));
    rst_n = 1'b0;
    #1;
    chk("midframe_reset", 128'({ra, rb, rt, sdin_a, bclk_a, lrck_a, mclk_a, ur_a, sdin_b, bclk_b, lrck_b, mclk_b, sdin_t, bclk_t, lrck_t, mclk_t}),
        128'(16'b1110000000000000));
    repeat (2) @(negedge clk);

    // Restart; TDM frame accepted during its first frame.
    rst_n = 1'b1;
    ur_base_t = ur_hi_t;
    vt = 1'b1; dt = {24'hA5A5A8, 24'hA5A5A7, 24'hA5A5A6, 24'hA5A5A5};
    fork
      capture(128);
      begin
        @(negedge clk);
        vt = 1'b0;
        chk("tdm_ready_drop", 128'(rt), 128'(1'b0));
      end
    join
    chk("post_reset_stereo_zero", 128'({sa[127:96], sb[127:96]}), 128'(64'h0));
    chk("post_reset_lrck_restart", 128'({la[127:96], lb[127:96]}), 128'({32'h0000_FFFF, 32'h0000_FFFF}));
    chk("tdm_f1_zero", st, 128'h0);
    chk("tdm_f1_lrck", lt, 128'h0);

    capture(128);
    chk("tdm_f2_data", st, {32'h52D2_D280, 32'h52D2_D300, 32'h52D2_D380, 32'h52D2_D400});
    chk("tdm_f2_fs", lt, {32'h8000_0000, 96'h0});
    chk("tdm_f1_end_no_underrun", 128'(ur_hi_t - ur_base_t), 128'(0));
    repeat (2) @(negedge clk);
    chk("tdm_f2_end_underrun", 128'(ur_hi_t - ur_base_t), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
